// File: rtl/router_1xn.sv
// router_1xn: one input packet stream steered to NUM_PORTS first-word
// fall-through FIFOs, with parity checking, dropping of invalid-address
// packets and a per-port idle-read timeout that flushes a stalled port.

// Per-port FIFO with its own idle-read timeout counter.
module router_1xn_port #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             full_o,
    output logic             flush_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q;
    logic             do_push, do_pop;

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign flush_o = (tmr_q == TMR_W'(TIMEOUT));
    // A flush on this edge overrides both a push and a pop.
    assign do_push = push_i & ~full_o & ~flush_o;
    assign do_pop  = rd_i & valid_o & ~flush_o;
    assign cnt_d   = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    assign rdata_o = valid_o ? mem_q[rd_q] : '0;

    // Storage array; no reset needed, occupancy qualifies the head.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    // Pointers, occupancy and the idle-read timer.
    always_ff @(posedge clock) begin
        if (reset || flush_o) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            tmr_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
            if (!valid_o || rd_i) tmr_q <= '0;
            else                  tmr_q <= tmr_q + 1'b1;
        end
    end
endmodule

module router_1xn #(
    parameter int WIDTH     = 8,
    parameter int NUM_PORTS = 3,
    parameter int DEPTH     = 16,
    parameter int TIMEOUT   = 30
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       pkt_valid,
    output logic                       busy,
    input  logic [NUM_PORTS-1:0]       read_enb,
    output logic [NUM_PORTS*WIDTH-1:0] data_out,
    output logic [NUM_PORTS-1:0]       valid_out,
    output logic                       error,
    output logic                       drop
);
    localparam int ADDR_W = $clog2(NUM_PORTS);
    localparam int LEN_W  = WIDTH - ADDR_W;
    localparam int NP2    = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, LOAD, PARITY, CHECK, DROP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   dest_q, dest_d;
    logic [LEN_W:0]      rem_q, rem_d;
    logic [WIDTH-1:0]    par_q, par_d;
    logic                error_q, err_d;
    logic                drop_q, drop_d;

    logic [ADDR_W-1:0]   hdr_addr, tgt;
    logic [LEN_W-1:0]    hdr_len;
    logic                addr_ok, accept, push_en;
    logic [NUM_PORTS-1:0] full_w, flush_w, push_w;
    // Zero-padded to the full address range so an invalid header address
    // can index them safely.
    logic [NP2-1:0]      full_pad, flush_pad;

    assign hdr_addr  = data_in[ADDR_W-1:0];
    assign hdr_len   = data_in[WIDTH-1:ADDR_W];
    assign addr_ok   = ({1'b0, hdr_addr} < (ADDR_W+1)'(NUM_PORTS));
    assign full_pad  = NP2'(full_w);
    assign flush_pad = NP2'(flush_w);
    assign accept    = pkt_valid & ~busy;
    assign push_w    = push_en ? (NUM_PORTS'(1) << tgt) : '0;
    assign error     = error_q;
    assign drop      = drop_q;

    // Back-pressure: only the destination FIFO's fullness matters; DROP
    // never stalls the source.
    always_comb begin
        busy = 1'b0;
        case (state_q)
            IDLE:         busy = pkt_valid & addr_ok & full_pad[hdr_addr];
            LOAD, PARITY: busy = full_pad[dest_q];
            CHECK:        busy = 1'b1;
            default:      busy = 1'b0;
        endcase
    end

    // Framing FSM: next state, FIFO write select, parity and pulses.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        rem_d   = rem_q;
        par_d   = par_q;
        tgt     = dest_q;
        push_en = 1'b0;
        err_d   = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tgt = hdr_addr;
                if (accept) begin
                    if (!addr_ok || flush_pad[hdr_addr]) begin
                        // Discard header plus len payload plus parity.
                        drop_d  = 1'b1;
                        rem_d   = {1'b0, hdr_len} + 1'b1;
                        state_d = DROP;
                    end else begin
                        push_en = 1'b1;
                        dest_d  = hdr_addr;
                        rem_d   = {1'b0, hdr_len};
                        par_d   = data_in;
                        state_d = (hdr_len == '0) ? PARITY : LOAD;
                    end
                end
            end
            LOAD: begin
                if (flush_pad[dest_q]) begin
                    // Rest of payload plus parity, less any word taken now.
                    drop_d  = 1'b1;
                    rem_d   = rem_q + (LEN_W+1)'(1) - (LEN_W+1)'(accept);
                    state_d = DROP;
                end else if (accept) begin
                    push_en = 1'b1;
                    par_d   = par_q ^ data_in;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == (LEN_W+1)'(1)) state_d = PARITY;
                end
            end
            PARITY: begin
                if (flush_pad[dest_q]) begin
                    drop_d = 1'b1;
                    if (accept) begin
                        state_d = IDLE;
                    end else begin
                        rem_d   = (LEN_W+1)'(1);
                        state_d = DROP;
                    end
                end else if (accept) begin
                    push_en = 1'b1;
                    err_d   = (data_in != par_q);
                    state_d = CHECK;
                end
            end
            CHECK: state_d = IDLE;
            DROP: begin
                if (accept) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == (LEN_W+1)'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            dest_q  <= '0;
            rem_q   <= '0;
            par_q   <= '0;
            error_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            rem_q   <= rem_d;
            par_q   <= par_d;
            error_q <= err_d;
            drop_q  <= drop_d;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        router_1xn_port #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .TIMEOUT(TIMEOUT)
        ) u_port (
            .clock  (clock),
            .reset  (reset),
            .push_i (push_w[i]),
            .wdata_i(data_in),
            .rd_i   (read_enb[i]),
            .rdata_o(data_out[i*WIDTH +: WIDTH]),
            .valid_o(valid_out[i]),
            .full_o (full_w[i]),
            .flush_o(flush_w[i])
        );
    end
endmodule

// File: tb/tb_router_1xn.sv
// Directed bench for router_1xn with a per-port expected-word scoreboard.
module tb_router_1xn;
    localparam int TO = 30;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        pkt_valid;
    logic        busy;
    logic [2:0]  read_enb;
    logic [23:0] data_out;
    logic [2:0]  valid_out;
    logic        error;
    logic        drop;

    router_1xn #(.WIDTH(8), .NUM_PORTS(3), .DEPTH(16), .TIMEOUT(TO)) dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .pkt_valid(pkt_valid),
        .busy     (busy),
        .read_enb (read_enb),
        .data_out (data_out),
        .valid_out(valid_out),
        .error    (error),
        .drop     (drop)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    int         cyc_n  = 0;
    int         cur_port;
    int         waits, wsum, k, n;
    int         pops [3];
    logic       last_acc, last_busy;
    logic [7:0] exp_q [3][$];
    logic [7:0] par, w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, note accept, check any pops this cycle.
    task automatic cyc(input logic v, input logic [7:0] d, input logic [2:0] rd);
        logic [7:0] e;
        @(negedge clock);
        cyc_n++;
        pkt_valid = v;
        data_in   = d;
        read_enb  = rd;
        #1;
        last_busy = busy;
        last_acc  = v & ~busy;
        for (int p = 0; p < 3; p++) begin
            if (rd[p] && valid_out[p]) begin
                e = 8'hxx;
                if (exp_q[p].size() > 0) e = exp_q[p].pop_front();
                chk("rd_data", data_out[p*8 +: 8], e);
                pops[p]++;
            end
        end
    endtask

    // Hold a word until accepted; expected copy goes to the scoreboard.
    task automatic send(input logic [7:0] d, input logic [2:0] rd);
        waits = 0;
        cyc(1'b1, d, rd);
        while (!last_acc && waits < 100) begin
            waits++;
            cyc(1'b1, d, rd);
        end
        chk("send_accept", last_acc, 1);
        if (last_acc && cur_port >= 0) exp_q[cur_port].push_back(d);
    endtask

    task automatic drain(input int p, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            cyc(1'b0, 8'h00, 3'(1 << p));
            chk("drain_valid", valid_out[p], 1);
        end
        cyc(1'b0, 8'h00, 3'b000);
        chk("drain_empty", valid_out[p], 0);
        chk("drain_sb", exp_q[p].size(), 0);
        chk("empty_zero", data_out[p*8 +: 8], 0);
    endtask

    task automatic check_reset_vals();
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_error", error, 0);
        chk("rst_drop", drop, 0);
        chk("rst_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = '0; read_enb = '0;
        for (int p = 0; p < 3; p++) pops[p] = 0;
        cyc(1'b0, 8'h00, 3'b000);
        cyc(1'b0, 8'h00, 3'b000);
        check_reset_vals();
        reset = 1'b0;

        // Good packet to port 1, reader idle.
        cur_port = 1;
        send(8'h0D, 3'b000); send(8'h11, 3'b000); send(8'h22, 3'b000);
        send(8'h33, 3'b000); send(8'h0D, 3'b000);
        cyc(1'b0, 8'h00, 3'b000);
        chk("check_busy", last_busy, 1);
        chk("good_error", error, 0);
        cyc(1'b0, 8'h00, 3'b000);
        chk("idle_busy", last_busy, 0);
        chk("p1_valid", valid_out, 3'b010);
        drain(1, 5);

        // Bad parity: error in CHECK cycle, packet kept intact.
        send(8'h0D, 3'b000); send(8'h11, 3'b000); send(8'h22, 3'b000);
        send(8'h33, 3'b000); send(8'h0C, 3'b000);
        cyc(1'b0, 8'h00, 3'b000);
        chk("bad_error", error, 1);
        cyc(1'b0, 8'h00, 3'b000);
        chk("error_pulse", error, 0);
        drain(1, 5);

        // Invalid address: whole packet absorbed.
        cur_port = -1;
        send(8'h07, 3'b000);
        chk("drop_busy0", last_busy, 0);
        send(8'hAA, 3'b000);
        chk("drop_busy1", last_busy, 0);
        chk("drop_pulse", drop, 1);
        send(8'hA9, 3'b000);
        chk("drop_busy2", last_busy, 0);
        chk("drop_end", drop, 0);
        chk("drop_novalid", valid_out, 0);
        cur_port = 2;
        send(8'h06, 3'b000);
        chk("after_drop_wait", waits, 0);
        send(8'h5A, 3'b000); send(8'h5C, 3'b000);
        drain(2, 3);

        // Port 0, len 20: back-pressure at 16 words then pointer wrap.
        cur_port = 0; pops[0] = 0;
        par = 8'h50;
        send(8'h50, 3'b000); wsum = waits;
        for (int i = 0; i < 15; i++) begin
            w = 8'h80 + 8'(i); par ^= w;
            send(w, 3'b000); wsum += waits;
        end
        chk("fill_nowait", wsum, 0);
        cyc(1'b1, 8'h8F, 3'b000);
        chk("full_busy", last_busy, 1);
        for (int i = 15; i < 20; i++) begin
            w = 8'h80 + 8'(i); par ^= w;
            send(w, 3'b001);
        end
        send(par, 3'b001);
        drain(0, exp_q[0].size());
        chk("wrap_count", pops[0], 22);

        // Unread packet: flush TIMEOUT+1 cycles after valid rises.
        cur_port = 2;
        send(8'h06, 3'b000); k = cyc_n;
        send(8'h5A, 3'b000); send(8'h5C, 3'b000);
        n = 0;
        while (valid_out[2] && n < 100) begin cyc(1'b0, 8'h00, 3'b000); n++; end
        chk("tmo_fall", cyc_n - (k + 1), TO + 1);
        chk("tmo_data", data_out[23:16], 0);
        exp_q[2].delete();

        // Flush while loading: remainder absorbed without stalls.
        send(8'h2A, 3'b000); send(8'h30, 3'b000); send(8'h31, 3'b000);
        n = 0;
        while (valid_out[2] && n < 100) begin cyc(1'b0, 8'h00, 3'b000); n++; end
        chk("flush_drop", drop, 1);
        exp_q[2].delete();
        cur_port = -1;
        cyc(1'b0, 8'h00, 3'b000);
        chk("flush_drop_end", drop, 0);
        par = 8'h2A ^ 8'h30 ^ 8'h31;
        wsum = 0;
        for (int i = 2; i < 10; i++) begin
            w = 8'h30 + 8'(i); par ^= w;
            send(w, 3'b000); wsum += waits;
        end
        send(par, 3'b000); wsum += waits;
        chk("absorb_nowait", wsum, 0);
        chk("absorb_novalid", valid_out, 0);
        cur_port = 1;
        send(8'h01, 3'b000); send(8'h01, 3'b000);
        drain(1, 2);

        // Reset mid-payload.
        send(8'h0D, 3'b000); send(8'h11, 3'b000);
        chk("pre_rst_valid", valid_out[1], 1);
        reset = 1'b1;
        cyc(1'b0, 8'h00, 3'b000);
        check_reset_vals();
        reset = 1'b0;
        for (int p = 0; p < 3; p++) exp_q[p].delete();
        send(8'h0D, 3'b000); send(8'h11, 3'b000); send(8'h22, 3'b000);
        send(8'h33, 3'b000); send(8'h0D, 3'b000);
        cyc(1'b0, 8'h00, 3'b000);
        chk("post_rst_error", error, 0);
        drain(1, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_1xn.md
# router_1xn

Parametrised 1-to-N packet router: the successor to the fixed 1x3 byte router, with configurable word width, output-port count and per-port FIFO depth. A single input stream carries framed packets (header, payload, parity). Each packet is steered to one of NUM_PORTS output FIFOs, and parity is checked on the way through. Over the fixed design it adds length-driven framing, explicit dropping of packets with an invalid address, a configurable read timeout, and correct mid-packet flush handling. It sits between the packet source and the N downstream readers.

## Interface
- WIDTH, 8 — data word width; must be ≥ ADDR_W+1.
- NUM_PORTS, 3 — output port count, 2..16.
- DEPTH, 16 — words per port FIFO; power of two, ≥ 2.
- TIMEOUT, 30 — number of idle-read cycles before a port is flushed; ≥ 1.
- Derived: ADDR_W = clog2(NUM_PORTS). LEN_W = WIDTH−ADDR_W.
- clock  in  1  — single clock; all logic is clocked on the rising edge.
- reset  in  1  — synchronous, active-high; clears all state on the edge where it is sampled high.
- data_in  in  WIDTH  — packet word.
- pkt_valid  in  1  — data_in holds a valid packet word.
- busy  out  1  — the router cannot accept data_in this cycle; the source holds the word.
- read_enb  in  NUM_PORTS  — per-port pop request.
- data_out  out  NUM_PORTS*WIDTH  — port i occupies bits [i*WIDTH +: WIDTH]; this is the FIFO head (first-word fall-through).
- valid_out  out  NUM_PORTS  — port i FIFO is non-empty.
- error  out  1  — one-cycle pulse on parity mismatch.
- drop  out  1  — one-cycle pulse when a packet is discarded.

## Operation
- Packet format:
  - Header: addr = data_in[ADDR_W-1:0], len = data_in[WIDTH-1:ADDR_W]; len may be 0.
  - Then len payload words.
  - Then 1 parity word = XOR of the header and all payload words.
- pkt_valid stays high for all len+2 words. A word is accepted when pkt_valid=1 and busy=0.
- Framing is driven by len, not by pkt_valid. pkt_valid=0 mid-packet is a stall, not an end-of-packet.
- FSM states: IDLE, LOAD, PARITY, CHECK, DROP.
- IDLE:
  - Header accepted with addr < NUM_PORTS: latch dest and remaining = len, write the header to FIFO[dest], go to LOAD (or to PARITY if len = 0). Running parity starts at the header value.
  - Header accepted with addr ≥ NUM_PORTS: pulse drop, set remaining = len+1, go to DROP. Nothing is written.
- LOAD: each accepted word is written to FIFO[dest], XORed into parity, and remaining is decremented. The accept that takes remaining from 1 to 0 goes to PARITY.
- PARITY: the accepted word is written to FIFO[dest] and compared with running parity. Go to CHECK.
- CHECK (one cycle, busy=1): error pulses if there was a mismatch. Go to IDLE. The bad packet stays in the FIFO intact.
- DROP: accepted words are discarded and remaining is decremented. The accept at remaining = 1 returns to IDLE.
- busy (combinational):
  - 1 in CHECK.
  - 1 in LOAD/PARITY when full[dest].
  - 1 in IDLE when pkt_valid and the header addr is valid and full[addr].
  - 0 otherwise, including throughout DROP.
- FIFO:
  - A pop happens when read_enb[i] & valid_out[i]; a pop on an empty FIFO is ignored.
  - A simultaneous push and pop is legal.
  - full is evaluated before any same-cycle pop.
  - Pointers wrap modulo DEPTH. An occupancy counter has ADDR(DEPTH)+1 bits.
  - data_out[i] reads 0 when the FIFO is empty.
- Timeout:
  - Per-port counter: increments while valid_out[i]=1 and read_enb[i]=0; clears on read_enb[i]=1 or when empty.
  - When the counter reaches TIMEOUT, FIFO i is flushed on the next edge (occupancy cleared) and the counter is cleared.
  - If the FSM is in LOAD/PARITY with dest = i at the flush edge: drop pulses, and the FSM goes to DROP with remaining = words left in the packet (0 remaining, i.e. at CHECK, goes to IDLE). No further words are written to port i.
  - If a push to port i coincides with its flush, the flush wins.

## Timing
- Reset values:
  - state = IDLE; all FIFOs empty.
  - valid_out = 0; data_out = 0.
  - error = 0; drop = 0.
  - busy = 0 while pkt_valid = 0.
  - All timeout counters = 0.
- A word accepted at edge t appears on data_out/valid_out after edge t (cycle t+1).
- A pop at edge t advances data_out in cycle t+1.
- error pulses in the cycle after parity acceptance. Back-to-back packets have exactly one bubble cycle (CHECK).
- The flush edge is TIMEOUT+1 cycles after valid_out rises with no reads.
- Reset mid-packet discards the packet and all FIFO contents; the next accepted word is a header.

## Test plan
- Default parameters, port 1, words 0x0D, 0x11, 0x22, 0x33, 0x0D, reader idle → FIFO1 holds those 5 words, error stays 0, busy is 1 for one cycle after the 5th accept.
- Same packet with the parity word set to 0x0C → error pulses one cycle after the parity accept, and FIFO1 still holds 5 words with 0x0C last.
- Header 0x07 (addr 3, len 1) with NUM_PORTS=3, then 0xAA and 0xA9 → drop pulses at header accept, busy stays 0, all valid_out stay 0, and the next header routes normally.
- Port 0, len 20, DEPTH=16, reader idle → busy asserts after 16 words; releasing read_enb[0] lets the packet complete, and all 22 words are read in order with a correct pointer wrap.
- A 3-word packet to port 2 is left unread → valid_out[2] falls exactly TIMEOUT+1 cycles after it rose; a repeat with flush during LOAD → drop pulses and the remaining words are absorbed without busy.
- Reset asserted mid-payload → the next cycle shows all outputs at reset values, and a fresh packet is then routed correctly.
